// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control stage for a 2**PTR_W entry FIFO.
//
// Sits directly upstream of the write/read pointer registers and the storage
// array. Converts producer push and consumer pop requests into per-cycle
// pointer strobes and the storage write enable. Also tracks occupancy and
// reports full / empty / almost_full plus sticky overflow / underflow flags.
//
// Ports:
//   ck          in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   push        in   producer write request this cycle
//   pop         in   consumer read request this cycle
//   clear       in   synchronous flush request (priority over push/pop)
//   clr_ptr     out  clear strobe to both pointer registers (combinational)
//   inc_wr      out  write-pointer increment strobe (combinational)
//   inc_rd      out  read-pointer increment strobe (combinational)
//   we          out  storage write enable, identical to inc_wr
//   full        out  occupancy == DEPTH (decoded from state register)
//   empty       out  occupancy == 0 (decoded from state register)
//   almost_full out  occupancy >= AF_LEVEL (registered)
//   count       out  occupancy 0..DEPTH (registered)
//   overflow    out  sticky: push rejected because FIFO was full
//   underflow   out  sticky: pop rejected because FIFO was empty
//   dbg_state   out  current FSM state (0 EMPTY, 1 PARTIAL, 2 FULL)
//
// Handshake: a request is a single-cycle level on push/pop. When the matching
// strobe (inc_wr / inc_rd) is high in that same cycle the request is taken on
// the next rising edge of ck; when the strobe is low the request is dropped
// (the requester is not stalled, and a dropped push while full or a dropped
// pop while empty raises the matching sticky error flag).
module fifo_ctrl #(
  parameter int PTR_W    = 4,
  parameter int AF_LEVEL = 14
) (
  input  logic             ck,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  output logic             clr_ptr,
  output logic             inc_wr,
  output logic             inc_rd,
  output logic             we,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow,
  output logic [1:0]       dbg_state
);

  localparam int             DEPTH   = 2 ** PTR_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] AF_C    = (PTR_W + 1)'(AF_LEVEL);
  localparam logic [PTR_W:0] ZERO_C  = '0;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W:0]   count_next;
  logic             af_next;
  logic             overflow_next;
  logic             underflow_next;
  logic             wr_ok;
  logic             rd_ok;

  // Full and empty come straight from the state register so they are glitch
  // free and agree with count by construction.
  assign full      = (state == ST_FULL);
  assign empty     = (state == ST_EMPTY);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Accept logic and strobes. A push into a full FIFO is still accepted when a
  // pop happens on the same edge: storage is read asynchronously, so the
  // oldest entry leaves before the freed slot is overwritten.
  // Strobes are held low during reset so pointers/storage see no activity.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ok   = push & (~full | pop);
    rd_ok   = pop & ~empty;
    clr_ptr = clear & reset_n;
    inc_wr  = wr_ok & ~clear & reset_n;
    inc_rd  = rd_ok & ~clear & reset_n;
    we      = inc_wr;
  end

  // ---------------------------------------------------------------------------
  // Next-state, next-count and flag logic.
  // count_next is computed in PTR_W+1 bits; the accept rules guarantee it
  // stays within 0..DEPTH, so no wrap handling is needed.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    count_next     = count;
    af_next        = almost_full;
    overflow_next  = overflow;
    underflow_next = underflow;

    if (clear) begin
      count_next     = ZERO_C;
      state_next     = ST_EMPTY;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      count_next = count + {{PTR_W{1'b0}}, wr_ok} - {{PTR_W{1'b0}}, rd_ok};

      if (push & full & ~pop) begin
        overflow_next = 1'b1;
      end
      if (pop & empty) begin
        underflow_next = 1'b1;
      end

      case (state)
        ST_EMPTY: begin
          if (wr_ok) begin
            state_next = ST_PARTIAL;
          end
        end
        ST_PARTIAL: begin
          if (count_next == DEPTH_C) begin
            state_next = ST_FULL;
          end else if (count_next == ZERO_C) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Push together with pop keeps the FIFO full.
          if (rd_ok & ~wr_ok) begin
            state_next = ST_PARTIAL;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end

    af_next = (count_next >= AF_C);
  end

  // ---------------------------------------------------------------------------
  // State register. Reset drops all occupancy; pointers have their own reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_EMPTY;
      count       <= ZERO_C;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      almost_full <= af_next;
      overflow    <= overflow_next;
      underflow   <= underflow_next;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed testbench for fifo_ctrl. Stimulus is applied on the falling edge;
// each step queues the expected strobes (checked mid-low-phase) and the
// expected registered outputs (checked just after the following rising edge).
module tb_fifo_ctrl;

  localparam int PTR_W = 4;
  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PARTIAL = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic             ck;
  logic             reset_n;
  logic             push;
  logic             pop;
  logic             clear;
  logic             clr_ptr;
  logic             inc_wr;
  logic             inc_rd;
  logic             we;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             underflow;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int step_id = 0;

  // Strobe word: {clr_ptr, inc_wr, inc_rd, we}
  logic [3:0]  strb_q[$];
  int          strb_id_q[$];
  // Register word: {count[4:0], full, empty, almost_full, overflow, underflow, state[1:0]}
  logic [11:0] exp_q[$];
  int          exp_id_q[$];

  fifo_ctrl #(.PTR_W(PTR_W), .AF_LEVEL(14)) dut (
    .ck          (ck),
    .reset_n     (reset_n),
    .push        (push),
    .pop         (pop),
    .clear       (clear),
    .clr_ptr     (clr_ptr),
    .inc_wr      (inc_wr),
    .inc_rd      (inc_rd),
    .we          (we),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  function automatic logic [3:0] cur_strb();
    return {clr_ptr, inc_wr, inc_rd, we};
  endfunction

  function automatic logic [11:0] cur_regs();
    return {count, full, empty, almost_full, overflow, underflow, dbg_state};
  endfunction

  // Driver: one request cycle plus its expected outcome.
  task automatic step(input logic p, input logic po, input logic c,
                      input logic [3:0] es, input int ec,
                      input logic ef, input logic ee, input logic eaf,
                      input logic eov, input logic eud, input logic [1:0] est);
    logic [4:0] ec5;
    @(negedge ck);
    push  = p;
    pop   = po;
    clear = c;
    ec5   = ec[4:0];
    step_id++;
    strb_q.push_back(es);
    strb_id_q.push_back(step_id);
    exp_q.push_back({ec5, ef, ee, eaf, eov, eud, est});
    exp_id_q.push_back(step_id);
  endtask

  // Monitor: combinational strobes, sampled mid low phase.
  always begin
    logic [3:0] exp_s;
    int         id;
    @(negedge ck);
    #4;
    if (strb_q.size() > 0) begin
      exp_s = strb_q.pop_front();
      id    = strb_id_q.pop_front();
      checks++;
      if (cur_strb() !== exp_s) begin
        errors++;
        $display("FAIL strobes step %0d: got %b expected %b", id, cur_strb(), exp_s);
      end
    end
  end

  // Monitor: registered outputs, sampled just after the rising edge.
  always begin
    logic [11:0] exp_r;
    int          id;
    @(posedge ck);
    #1;
    if (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      id    = exp_id_q.pop_front();
      checks++;
      if (cur_regs() !== exp_r) begin
        errors++;
        $display("FAIL regs step %0d: got cnt=%0d f/e/af/ov/ud/st=%b expected cnt=%0d f/e/af/ov/ud/st=%b",
                 id, cur_regs()[11:7], cur_regs()[6:0], exp_r[11:7], exp_r[6:0]);
      end
    end
  end

  // Direct check used only while reset is asserted (no clock edge involved).
  task automatic check_reset_state(input string name);
    logic [11:0] exp_r;
    exp_r = {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_EMPTY};
    checks++;
    if (cur_regs() !== exp_r) begin
      errors++;
      $display("FAIL %s regs: got %b expected %b", name, cur_regs(), exp_r);
    end
    checks++;
    if (cur_strb() !== 4'b0000) begin
      errors++;
      $display("FAIL %s strobes: got %b expected 0000", name, cur_strb());
    end
  endtask

  initial begin
    reset_n = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    #1;
    // Reset with every request asserted: strobes must stay low.
    reset_n = 1'b0;
    push    = 1'b1;
    pop     = 1'b1;
    clear   = 1'b1;
    #1;
    check_reset_state("reset");
    @(negedge ck);
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    @(negedge ck);
    reset_n = 1'b1;

    // Idle 5 cycles
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, S_EMPTY);

    // Fill with 16 pushes
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 4'b0101, i + 1, (i == 15), 0, (i + 1 >= 14), 0, 0,
           (i == 15) ? S_FULL : S_PARTIAL);

    // 17th push rejected
    step(1, 0, 0, 4'b0000, 16, 1, 0, 1, 1, 0, S_FULL);

    // Push & pop while full, 3 cycles
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 4'b0111, 16, 1, 0, 1, 1, 0, S_FULL);

    // Drain to 7
    for (int i = 0; i < 9; i++)
      step(0, 1, 0, 4'b0010, 15 - i, 0, 0, (15 - i >= 14), 1, 0, S_PARTIAL);

    // Clear beats push & pop, and clears overflow
    step(1, 1, 1, 4'b1000, 0, 0, 1, 0, 0, 0, S_EMPTY);

    // Pop while empty: underflow
    step(0, 1, 0, 4'b0000, 0, 0, 1, 0, 0, 1, S_EMPTY);

    // Push & pop while empty: only push taken
    step(1, 1, 0, 4'b0101, 1, 0, 0, 0, 0, 1, S_PARTIAL);

    // Push to 9
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 4'b0101, 2 + i, 0, 0, 0, 0, 1, S_PARTIAL);

    // Push & pop while partial: count unchanged
    step(1, 1, 0, 4'b0111, 9, 0, 0, 0, 0, 1, S_PARTIAL);

    // Asynchronous reset mid-cycle, away from any edge
    @(posedge ck);
    #2;
    push    = 1'b1;
    pop     = 1'b0;
    clear   = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge ck);
    push    = 1'b0;
    reset_n = 1'b1;

    // Resume normal operation
    step(1, 0, 0, 4'b0101, 1, 0, 0, 0, 0, 0, S_PARTIAL);
    step(1, 0, 0, 4'b0101, 2, 0, 0, 0, 0, 0, S_PARTIAL);
    step(0, 1, 0, 4'b0010, 1, 0, 0, 0, 0, 0, S_PARTIAL);
    step(0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, S_PARTIAL);

    // Let the monitors drain, bounded
    for (int i = 0; i < 20 && (exp_q.size() > 0 || strb_q.size() > 0); i++)
      @(posedge ck);
    #3;
    checks++;
    if (exp_q.size() != 0 || strb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reg and %0d strobe expectations left, expected 0",
               exp_q.size(), strb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Control stage for the 16-entry FIFO. It sits directly upstream of the write and read pointer registers and the storage array. It takes producer/consumer push/pop requests and generates the per-cycle clear and increment strobes for both pointers plus the memory write enable. It tracks occupancy and exposes full, empty and almost-full status, along with sticky overflow/underflow error flags.

Parameters:
PTR_W, 4, pointer width; FIFO depth DEPTH = 2**PTR_W (16).
AF_LEVEL, 14, occupancy at or above which almost_full asserts (1..DEPTH).

Ports:
ck  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
push  input  1  producer write request this cycle.
pop  input  1  consumer read request this cycle.
clear  input  1  synchronous flush request.
clr_ptr  output  1  clear strobe to both pointer registers (combinational).
inc_wr  output  1  write-pointer increment strobe (combinational).
inc_rd  output  1  read-pointer increment strobe (combinational).
we  output  1  storage write enable; equal to inc_wr.
full  output  1  occupancy == DEPTH (registered).
empty  output  1  occupancy == 0 (registered).
almost_full  output  1  occupancy >= AF_LEVEL (registered).
count  output  PTR_W+1  current occupancy 0..DEPTH (registered).
overflow  output  1  sticky: push rejected because FIFO was full.
underflow  output  1  sticky: pop rejected because FIFO was empty.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = EMPTY, count = 0, empty = 1.
  - full, almost_full, overflow, underflow = 0.
  - Strobe outputs are 0 while reset_n is low.
  - Reset mid-operation discards all occupancy. Pointers are reset by their own reset.
- FSM states: EMPTY (count 0), PARTIAL (1..DEPTH-1), FULL (count DEPTH). Full and empty are decoded from the state register.
- Accept rules, combinational from the current state and the inputs:
  - wr_ok = push & (~full | pop).
  - rd_ok = pop & ~empty.
  - inc_wr = we = wr_ok & ~clear.
  - inc_rd = rd_ok & ~clear.
  - clr_ptr = clear.
- Strobes are asserted in the same cycle as the request. Pointers and memory update on that rising edge, so there is zero-cycle acceptance latency.
- Simultaneous push & pop:
  - In PARTIAL: both are accepted, count is unchanged, state is unchanged.
  - In FULL: both are accepted. The read of the oldest entry and the write to the freed slot happen on the same edge (storage read is asynchronous). Count stays DEPTH.
  - In EMPTY: push is accepted, pop is rejected, underflow is set. Next state is PARTIAL with count 1.
- Count update: count_next = count + wr_ok − rd_ok, computed in PTR_W+1 bits; it never wraps.
- Transitions:
  - EMPTY→PARTIAL on accepted push.
  - PARTIAL→FULL when count_next == DEPTH.
  - PARTIAL→EMPTY when count_next == 0.
  - FULL→PARTIAL on pop without push.
  - Any state→EMPTY on clear.
- Pointer wrap is handled by the pointer modulo 2**PTR_W. The controller never asserts clr_ptr for wrap.
- Error flags:
  - overflow sets on push & full & ~pop & ~clear.
  - underflow sets on pop & empty & ~clear.
  - Both are sticky until clear or reset.
  - A rejected request produces no strobe and no count change.
- clear has priority over push/pop:
  - inc_wr, inc_rd and we are forced to 0.
  - On the next edge: count = 0, state = EMPTY, overflow = underflow = 0.
- almost_full is registered from count_next. With the default AF_LEVEL it is 1 for count 14..16.

Test Plan:
- Reset then idle 5 cycles → empty=1, full=0, count=0, all strobes 0, no flags.
- 16 consecutive push cycles from empty → inc_wr/we high each cycle; almost_full rises after the 14th edge; full=1 and count=16 after the 16th edge; 17th push → inc_wr=0, overflow=1, count stays 16.
- From full, push & pop together for 3 cycles → inc_wr=inc_rd=1 each cycle, count=16, full stays 1, overflow unchanged.
- From empty, pop alone → inc_rd=0, underflow=1, count=0; then push & pop together → inc_wr=1, inc_rd=0, count=1, state PARTIAL.
- With count=7 and overflow=1, assert clear with push & pop → clr_ptr=1, inc_wr=inc_rd=we=0; next cycle count=0, empty=1, overflow=0.
- Drop reset_n asynchronously mid-cycle with count=9 → count=0, empty=1, flags 0 immediately, without waiting for a ck edge; normal operation resumes after release.
